// File: rtl/mod_multisource_pkg.sv
// Shared types and constants for the multi-channel oscillator sample generator.
package mod_multisource_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEL_INC   = 2'd0,
        SEL_AMP   = 2'd1,
        SEL_MODE  = 2'd2,
        SEL_PHASE = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic signed [15:0] WAVE_MAX = 16'sh7fff;
    localparam logic signed [15:0] WAVE_MIN = 16'sh8000;

endpackage

// File: rtl/mod_multisource_sine16.sv
// Parabolic sine approximation. One full period spans angle 0..32767;
// each half-wave is x*(16384-x)/2048, saturated to WAVE_MAX.
module mod_sine16
    import mod_multisource_pkg::*;
(
    input  logic        [15:0] angle,
    output logic signed [15:0] sine
);

    logic [13:0] x;
    logic [28:0] prod;
    logic [28:0] scaled;
    logic [15:0] mag;

    always_comb begin
        x      = angle[13:0];
        prod   = 29'(x) * (29'd16384 - 29'(x));
        scaled = prod >> 11;
        // peak of the parabola lands exactly on 32768, clip it
        mag    = (scaled > 29'd32767) ? $unsigned(WAVE_MAX) : scaled[15:0];
        sine   = (angle[15] ^ angle[14]) ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/mod_multisource.sv
// Multi-channel phase-accumulator oscillator; one sample per channel per tick,
// handed out through a valid/ready hold stage.
//
// state   | meaning
// IDLE    | waiting for i_tick, no frame in progress
// CALC    | compute and register the sample of channel idx, advance its phase
// HOLD    | sample presented, wait for i_ready
module mod_multisource
    import mod_multisource_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_tick,
    input  logic                    i_cfg_we,
    input  logic [CH_W-1:0]         i_cfg_ch,
    input  logic [1:0]              i_cfg_sel,
    input  logic [31:0]             i_cfg_data,
    output logic signed [OUT_W-1:0] o_sample,
    output logic [CH_W-1:0]         o_ch,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic                    o_overrun
);

    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [PHASE_W-1:0] phase [NUM_CH];
    logic [PHASE_W-1:0] inc   [NUM_CH];
    logic [15:0]        amp   [NUM_CH];
    mode_e              mode  [NUM_CH];

    state_e             state;
    logic [CH_W-1:0]    idx;

    logic               cfg_ok;
    logic [15:0]        t;
    logic signed [15:0] sine_out;
    logic signed [15:0] wave;
    logic signed [32:0] prod;

    assign cfg_ok = i_cfg_we && ({1'b0, i_cfg_ch} < NUM_CH_L);
    assign t      = phase[idx][PHASE_W-1 -: 16];

    mod_sine16 u_sine (
        .angle (({1'b0, t[15:1]})),
        .sine  (sine_out)
    );

    always_comb begin
        wave = '0;
        unique case (mode[idx])
            MODE_SINE:   wave = sine_out;
            MODE_SQUARE: wave = t[15] ? -WAVE_MAX : WAVE_MAX;
            MODE_SAW:    wave = $signed({~t[15], t[14:0]});
            MODE_TRI:    wave = t[15] ? WAVE_MAX - $signed({t[14:0], 1'b0})
                                      : WAVE_MIN + $signed({t[14:0], 1'b0});
            default:     wave = '0;
        endcase
        prod = wave * $signed({1'b0, amp[idx]});
    end

    // Config writes come after the phase advance so a same-cycle phase load wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                amp[i]   <= '0;
                mode[i]  <= MODE_SINE;
            end
        end else begin
            if (state == ST_CALC)
                phase[idx] <= phase[idx] + inc[idx];
            if (cfg_ok) begin
                unique case (cfg_sel_e'(i_cfg_sel))
                    SEL_INC:   inc[i_cfg_ch]   <= PHASE_W'(i_cfg_data);
                    SEL_AMP:   amp[i_cfg_ch]   <= i_cfg_data[15:0];
                    SEL_MODE:  mode[i_cfg_ch]  <= mode_e'(i_cfg_data[1:0]);
                    SEL_PHASE: phase[i_cfg_ch] <= PHASE_W'(i_cfg_data);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            o_sample  <= '0;
            o_ch      <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (i_tick && o_busy)
                o_overrun <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (i_tick) begin
                        state  <= ST_CALC;
                        idx    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_CALC: begin
                    o_sample <= OUT_W'(prod);
                    o_ch     <= idx;
                    o_valid  <= 1'b1;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (idx == LAST_CH) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_CALC;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
